// File: rtl/pipeline_adder_seg_if.sv
// Operand/result bundle for the segmented pipelined adder.
// The master drives operands and control; the slave returns the aligned results.
interface pipeline_adder_seg_if #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_NUM_SEG    = 4
);
  logic [P_DATA_WIDTH-1:0] i_seed;
  logic                    i_en;
  logic                    i_valid;
  logic                    i_sub;
  logic [P_DATA_WIDTH-1:0] i_a;
  logic [P_DATA_WIDTH-1:0] i_b;
  logic                    i_cin;
  logic                    o_valid;
  logic [P_DATA_WIDTH-1:0] o_sum;
  logic                    o_cout;
  logic [P_NUM_SEG-1:0]    o_cout_seg;
  logic                    o_ovf;

  modport master (
    output i_seed, i_en, i_valid, i_sub, i_a, i_b, i_cin,
    input  o_valid, o_sum, o_cout, o_cout_seg, o_ovf
  );

  modport slave (
    input  i_seed, i_en, i_valid, i_sub, i_a, i_b, i_cin,
    output o_valid, o_sum, o_cout, o_cout_seg, o_ovf
  );
endinterface

// File: rtl/pipeline_adder_seg.sv
// Segmented pipelined add/sub: one slice per stage with a registered inter-slice carry,
// input skew and output deskew so every result bit and flag leaves on the same cycle.
module pipeline_adder_seg #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_SEG_WIDTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pipeline_adder_seg_if.slave  bus
);
  localparam int P_NUM_SEG = P_DATA_WIDTH / P_SEG_WIDTH;
  localparam int SW        = P_SEG_WIDTH;

  logic [P_DATA_WIDTH-1:0]        b_eff;
  logic                           c0;
  logic [P_NUM_SEG-1:0]           c_stage;   // stage-register carry of each slice
  logic [P_NUM_SEG-1:0][SW-1:0]   sum_out;
  logic [P_NUM_SEG-1:0]           cout_out;
  logic                           ovf_q;
  logic [P_NUM_SEG-1:0]           vld_pipe;

  // Subtract is a + ~b + ~cin, so the borrow-in inverts alongside B.
  assign b_eff = bus.i_sub ? ~bus.i_b : bus.i_b;
  assign c0    = bus.i_sub ^ bus.i_cin;

  for (genvar k = 0; k < P_NUM_SEG; k++) begin : g_seg
    localparam int D = P_NUM_SEG - 1 - k;

    logic [SW-1:0] a_s, b_s;
    logic          c_s;
    logic [SW:0]   add_w;
    logic [D:0][SW-1:0] sum_q;
    logic [D:0]         cy_q;

    if (k == 0) begin : g_in
      assign a_s = bus.i_a[SW-1:0];
      assign b_s = b_eff[SW-1:0];
      assign c_s = c0;
    end else begin : g_skew
      logic [k-1:0][SW-1:0] a_q, b_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (bus.i_en) begin
          a_q[0] <= bus.i_a[k*SW +: SW];
          b_q[0] <= b_eff[k*SW +: SW];
          for (int j = 1; j < k; j++) begin
            a_q[j] <= a_q[j-1];
            b_q[j] <= b_q[j-1];
          end
        end
      end
      assign a_s = a_q[k-1];
      assign b_s = b_q[k-1];
      assign c_s = c_stage[k-1];
    end

    assign add_w = {1'b0, a_s} + {1'b0, b_s} + (SW+1)'(c_s);

    // Index 0 is the stage register; the rest delay it until the top slice catches up.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sum_q <= {(D+1){bus.i_seed[k*SW +: SW]}};
        cy_q  <= '0;
      end else if (bus.i_en) begin
        sum_q[0] <= add_w[SW-1:0];
        cy_q[0]  <= add_w[SW];
        for (int j = 1; j <= D; j++) begin
          sum_q[j] <= sum_q[j-1];
          cy_q[j]  <= cy_q[j-1];
        end
      end
    end

    assign c_stage[k]  = cy_q[0];
    assign sum_out[k]  = sum_q[D];
    assign cout_out[k] = cy_q[D];

    if (k == P_NUM_SEG - 1) begin : g_ovf
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          ovf_q <= 1'b0;
        else if (bus.i_en)
          ovf_q <= a_s[SW-1] ^ b_s[SW-1] ^ add_w[SW-1] ^ add_w[SW];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
    end else if (bus.i_en) begin
      vld_pipe[0] <= bus.i_valid;
      for (int j = 1; j < P_NUM_SEG; j++) vld_pipe[j] <= vld_pipe[j-1];
    end
  end

  assign bus.o_valid    = vld_pipe[P_NUM_SEG-1];
  assign bus.o_sum      = sum_out;
  assign bus.o_cout     = c_stage[P_NUM_SEG-1];
  assign bus.o_cout_seg = cout_out;
  assign bus.o_ovf      = ovf_q;
endmodule

// File: tb/tb_pipeline_adder_seg.sv
// Scoreboard bench for pipeline_adder_seg in three geometries (16/4, 16/16, 24/8)
// driven by one shared stimulus stream.
module tb_pipeline_adder_seg;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        valid = 1'b0;
  logic        sub   = 1'b0;
  logic        cin   = 1'b0;
  logic [23:0] a_drv = '0;
  logic [23:0] b_drv = '0;
  logic [23:0] seed  = 24'h5AA5C3;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  seg;
    int          issue;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference from whole-word sums: slice carry k is the carry into bit SW*(k+1).
  function automatic exp_t model(input int w, input int sw, input logic [23:0] a,
                                 input logic [23:0] b, input logic s, input logic ci);
    exp_t r;
    logic [31:0] m, aa, bb, full, low, sm, part;
    logic c;
    m    = (32'd1 << w) - 32'd1;
    aa   = {8'd0, a} & m;
    bb   = (s ? ~{8'd0, b} : {8'd0, b}) & m;
    c    = s ^ ci;
    full = aa + bb + 32'(c);
    low  = (aa & (m >> 1)) + (bb & (m >> 1)) + 32'(c);
    r.sum  = full[23:0] & m[23:0];
    r.cout = full[w];
    r.ovf  = low[w-1] ^ full[w];
    r.seg  = '0;
    for (int k = 0; k < w / sw; k++) begin
      sm   = (32'd1 << (sw * (k + 1))) - 32'd1;
      part = (aa & sm) + (bb & sm) + 32'(c);
      r.seg[k] = part[sw * (k + 1)];
    end
    r.issue = 0;
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 2) ? 24 : 16;
    localparam int SW = (g == 0) ? 4 : (g == 1) ? 16 : 8;
    localparam int N  = W / SW;

    pipeline_adder_seg_if #(.P_DATA_WIDTH(W), .P_NUM_SEG(N)) bus ();

    assign bus.i_seed  = seed[W-1:0];
    assign bus.i_en    = en;
    assign bus.i_valid = valid;
    assign bus.i_sub   = sub;
    assign bus.i_a     = a_drv[W-1:0];
    assign bus.i_b     = b_drv[W-1:0];
    assign bus.i_cin   = cin;

    pipeline_adder_seg #(.P_DATA_WIDTH(W), .P_SEG_WIDTH(SW)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );

    exp_t        q[$];
    int          cnt    = 0;
    logic        upd    = 1'b0;
    logic [63:0] snap_q = '0;

    always @(posedge clk) begin
      upd = rst_n && en;
      if (upd) begin
        exp_t e;
        cnt++;
        if (valid) begin
          e = model(W, SW, a_drv, b_drv, sub, cin);
          e.issue = cnt;
          q.push_back(e);
        end
      end
    end

    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
      logic [63:0] snap;
      exp_t e;
      snap = 64'({bus.o_valid, bus.o_cout, bus.o_ovf, bus.o_cout_seg, bus.o_sum});
      if (!rst_n) begin
        chk($sformatf("i%0d_rst_sum", g), 64'(bus.o_sum), 64'(seed[W-1:0]));
        chk($sformatf("i%0d_rst_flags", g),
            64'({bus.o_valid, bus.o_cout, bus.o_ovf, bus.o_cout_seg}), 64'd0);
      end else if (!upd) begin
        chk($sformatf("i%0d_hold", g), snap, snap_q);
      end else if (bus.o_valid) begin
        if (q.size() == 0) begin
          chk($sformatf("i%0d_spurious_valid", g), 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("i%0d_sum", g), 64'(bus.o_sum), 64'(e.sum & 24'((32'd1 << W) - 1)));
          chk($sformatf("i%0d_cout", g), 64'(bus.o_cout), 64'(e.cout));
          chk($sformatf("i%0d_cout_seg", g), 64'(bus.o_cout_seg), 64'(e.seg));
          chk($sformatf("i%0d_ovf", g), 64'(bus.o_ovf), 64'(e.ovf));
          chk($sformatf("i%0d_latency", g), 64'(cnt - e.issue), 64'(N - 1));
        end
      end
      snap_q = snap;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [23:0] av,
                       input logic [23:0] bv, input logic c);
    valid = v; sub = s; a_drv = av; b_drv = bv; cin = c;
    @(posedge clk); #1;
  endtask

  initial begin
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Release with the pipeline frozen: seed must persist until an enabled edge.
    en = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;

    drive(1, 0, 24'hFFFFFF, 24'h000001, 0);   // full ripple
    drive(1, 0, 24'h007FFF, 24'h000001, 0);   // signed overflow
    drive(1, 0, 24'h001234, 24'h004321, 0);
    drive(1, 1, 24'h008000, 24'h000001, 0);   // subtract with overflow
    drive(1, 1, 24'h000000, 24'h000001, 1);   // borrow
    repeat (4) drive(0, 0, 24'h0, 24'h0, 0);

    // Stall for 5 cycles after two ops; junk on the inputs must be ignored.
    drive(1, 0, 24'h0A0A0A, 24'h050505, 1);
    drive(1, 1, 24'h100000, 24'h0FFFFF, 0);
    en = 1'b0;
    repeat (5) drive(1, 1, 24'($urandom), 24'($urandom), 1);
    en = 1'b1;
    drive(1, 0, 24'h00FFFF, 24'h00FFFF, 1);
    drive(1, 1, 24'h123456, 24'h654321, 1);
    repeat (4) drive(0, 0, 24'h0, 24'h0, 0);

    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      drive(1'($urandom), 1'($urandom), 24'($urandom), 24'($urandom), 1'($urandom));
    end
    en = 1'b1;
    repeat (4) drive(0, 0, 24'h0, 24'h0, 0);

    // Mid-flight reset with three ops in the pipe.
    drive(1, 0, 24'h111111, 24'h222222, 0);
    drive(1, 0, 24'h333333, 24'h444444, 1);
    drive(1, 1, 24'h555555, 24'h111111, 0);
    seed = 24'h111111;
    #1 rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) drive(0, 0, 24'h0, 24'h0, 0);

    drive(1, 0, 24'hFFFFFF, 24'h000001, 0);
    drive(1, 1, 24'h000000, 24'h000001, 1);
    repeat (6) drive(0, 0, 24'h0, 24'h0, 0);

    chk("i0_drain", 64'(g_dut[0].q.size()), 64'd0);
    chk("i1_drain", 64'(g_dut[1].q.size()), 64'd0);
    chk("i2_drain", 64'(g_dut[2].q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_adder_seg.md
# pipeline_adder_seg

Parametrised, segmented, fully pipelined adder/subtractor for the modulator datapath. Splits a P_DATA_WIDTH operand pair into P_SEG_WIDTH slices, resolves one slice per stage with a registered inter-slice carry, and deskews the results so all sum bits, carries and flags leave on the same cycle. Successor to the fixed 8-bit two-stage adder. Adds a valid pipeline, global stall, subtract mode, per-slice carry taps and signed overflow; keeps seed-on-reset.

## Interface
- P_DATA_WIDTH, 16, operand/sum width; must be an integer multiple of P_SEG_WIDTH.
- P_SEG_WIDTH, 4, slice width; bits resolved per stage.
- P_NUM_SEG, P_DATA_WIDTH/P_SEG_WIDTH (derived, localparam), stage count = latency.
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_seed  input  P_DATA_WIDTH  reset value of o_sum; static while i_rst_n low.
- i_en  input  1  pipeline advance; 0 freezes every register.
- i_valid  input  1  operands on this cycle are valid.
- i_sub  input  1  0: a+b+cin; 1: a-b-cin.
- i_a  input  P_DATA_WIDTH  operand A (unsigned or two's complement).
- i_b  input  P_DATA_WIDTH  operand B.
- i_cin  input  1  carry-in (add) / borrow-in (sub).
- o_valid  output  1  outputs correspond to a valid input.
- o_sum  output  P_DATA_WIDTH  result, modulo 2^P_DATA_WIDTH.
- o_cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
- o_cout_seg  output  P_NUM_SEG  carry out of each slice, bit k = slice k, aligned with o_sum.
- o_ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- Effective operation: B' = i_sub ? ~i_b : i_b; c0 = i_sub ? ~i_cin : i_cin; result = i_a + B' + c0. Subtract thus yields a - b - cin.
- Stage 0 adds slice 0 of A, B' with c0 combinationally and registers sum slice 0 and its carry.
- Stage k (1..P_NUM_SEG-1) adds slice k of A/B', delayed k cycles through input skew registers, with the registered carry from stage k-1.
- Sum slices and slice carries from stage k pass through P_NUM_SEG-1-k deskew registers. All reach the output register set together.
- o_ovf is computed in the last stage from the carry into and out of the MSB, then registered with the rest.
- Valid shift register of depth P_NUM_SEG tracks i_valid. Datapath registers load regardless of valid; only o_valid qualifies the data.
- i_en=0: every register (skew, carry, deskew, valid, outputs) holds its value. No bubble is inserted and no data is lost.
- Inputs are sampled only on edges with i_en=1.
- P_NUM_SEG=1 degenerates to a single registered adder, latency 1.

## Timing
- Latency: P_NUM_SEG enabled edges from the sampling edge to o_* updating. Default 4.
- Throughput: one operation per enabled cycle, back-to-back, with no dependency between consecutive operations.
- Reset (i_rst_n low, asynchronous):
  - o_sum = i_seed; internal sum-slice/deskew registers load their i_seed slices.
  - o_valid = 0, o_cout = 0, o_cout_seg = 0, o_ovf = 0.
  - All skew registers, carry registers and the valid chain clear to 0.
- Reset asserted mid-operation: all in-flight operations are discarded and outputs return to reset values immediately. After deassertion, o_valid stays 0 until a valid input has traversed P_NUM_SEG enabled edges.
- Deassertion is synchronous to i_clk by the system. The block adds no synchroniser.
- Carry propagation across all slices needs no extra cycles; a full-width ripple completes within the fixed latency.
- i_sub, i_cin and i_a/i_b are all captured on the same edge. i_sub does not need to be stable across operations.

## Test plan
- Reset with i_seed=0xA5C3, hold 3 cycles → o_sum=0xA5C3, o_valid=0, o_cout=0, o_cout_seg=0, o_ovf=0; the values persist until the first enabled edge after release.
- Full ripple: i_a=0xFFFF, i_b=0x0001, i_cin=0, i_sub=0 → after 4 edges o_sum=0x0000, o_cout=1, o_cout_seg=4'b1111, o_ovf=0, o_valid=1.
- Back-to-back stream: 0x7FFF+0x0001 then 0x1234+0x4321 then 0x8000-0x0001 (i_sub=1) on consecutive cycles.
  - Results on consecutive cycles: 0x8000 with o_ovf=1; 0x5555 with o_ovf=0; 0x7FFF with o_ovf=1, o_cout=1.
- Borrow: i_sub=1, i_a=0x0000, i_b=0x0001, i_cin=1 → o_sum=0xFFFE, o_cout=0.
- Stall: issue 4 operations, drop i_en for 5 cycles after the 2nd edge → outputs frozen during the stall; all 4 results emerge in order, none lost or duplicated.
- Mid-flight reset: pulse i_rst_n low with 3 ops in flight and i_seed=0x1111 → o_sum=0x1111 and o_valid=0 immediately. No stale result appears after release.
- Re-run the full-ripple and borrow cases with P_SEG_WIDTH=16 (latency 1) and with P_DATA_WIDTH=24, P_SEG_WIDTH=8 (latency 3).
